// File: rtl/sw_debounce_capture.sv
// Slide-switch conditioner: two-flop synchroniser, per-bit debounce, sticky
// both-edge capture and a PIO-compatible read/write register map with level irq.
module sw_debounce_capture #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
);

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } addr_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_prev_q, stable_prev_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] clr_bits;
    addr_e            addr;

    assign addr = addr_e'(address);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        sync1_d       = sw_in;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        mask_d        = mask_q;
        rdata_d       = rdata_q;
        clr_bits      = '0;

        // A mismatch must persist DEBOUNCE_CYCLES consecutive cycles; any return
        // to the accepted level restarts the count.
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end

        if (write && addr == ADDR_EDGE) clr_bits = writedata;
        if (write && addr == ADDR_MASK) mask_d   = writedata;

        // Set term is OR-ed after the clear so a simultaneous edge is never lost.
        cap_d = (cap_q & ~clr_bits) | (stable_q ^ stable_prev_q);
        irq_d = |(cap_q & mask_q);

        if (read) begin
            unique case (addr)
                ADDR_DATA: rdata_d = stable_q;
                ADDR_MASK: rdata_d = mask_q;
                ADDR_EDGE: rdata_d = cap_q;
                ADDR_RSVD: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        // NOTE: state uses non-blocking assignments so every flop sees pre-edge values.
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            // NOTE: the counter array is reset too, so a partial count never survives reset.
            cnt_q         <= '{default: '0};
            stable_q      <= '0;
            stable_prev_q <= '0;
            cap_q         <= '0;
            mask_q        <= '0;
            rdata_q       <= '0;
            irq_q         <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            cap_q         <= cap_d;
            mask_q        <= mask_d;
            rdata_q       <= rdata_d;
            irq_q         <= irq_d;
        end
    end

    assign readdata     = rdata_q;
    assign sw_stable    = stable_q;
    assign edge_capture = cap_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_sw_debounce_capture.sv
// Directed bench for sw_debounce_capture with DEBOUNCE_CYCLES=4; expected values
// are hand-computed cycle offsets from each stimulus change.
module tb_sw_debounce_capture;

    localparam int W = 4;

    logic         CLOCK_50 = 1'b0;
    logic         reset;
    logic [W-1:0] sw_in;
    logic [1:0]   address;
    logic         read;
    logic         write;
    logic [W-1:0] writedata;
    logic [W-1:0] readdata;
    logic [W-1:0] sw_stable;
    logic [W-1:0] edge_capture;
    logic         irq;

    int n_cmp = 0;
    int n_bad = 0;

    sw_debounce_capture #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .sw_in       (sw_in),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .sw_stable   (sw_stable),
        .edge_capture(edge_capture),
        .irq         (irq)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick(1);
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        read    = 1'b1;
        tick(1);
        read    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sw_in = '0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
        tick(3);
        check("rst_stable", 32'(sw_stable), 32'h0);
        check("rst_cap",    32'(edge_capture), 32'h0);
        check("rst_irq",    32'(irq), 32'h0);
        check("rst_rdata",  32'(readdata), 32'h0);
        reset = 1'b0;
        tick(10);

        // Clean rise on bit0: sw_stable at +6, edge_capture at +7
        sw_in = 4'b0001;
        tick(5);
        check("clean_early", 32'(sw_stable), 32'h0);
        tick(1);
        check("clean_stable", 32'(sw_stable), 32'h1);
        check("clean_cap_lag", 32'(edge_capture), 32'h0);
        tick(1);
        check("clean_cap", 32'(edge_capture), 32'h1);
        check("clean_irq_masked", 32'(irq), 32'h0);

        // Bounce on bit1: 1,0,1 with 2-cycle gaps; acceptance 6 cycles after final edge
        sw_in = 4'b0011; tick(2);
        sw_in = 4'b0001; tick(2);
        sw_in = 4'b0011; tick(5);
        check("bounce_early", 32'(sw_stable), 32'h1);
        tick(1);
        check("bounce_stable", 32'(sw_stable), 32'h3);
        tick(1);
        check("bounce_cap", 32'(edge_capture), 32'h3);
        bus_write(2'd3, 4'b1111);
        check("w1c_all", 32'(edge_capture), 32'h0);
        tick(4);
        check("bounce_once", 32'(edge_capture), 32'h0);

        // Bit1 fall with mask 0, then mask bit1 and a clean rise drives irq
        sw_in = 4'b0001; tick(7);
        check("fall_cap", 32'(edge_capture), 32'h2);
        bus_write(2'd3, 4'b0010);
        check("fall_clr", 32'(edge_capture), 32'h0);
        bus_write(2'd2, 4'b0010);
        check("mask_irq0", 32'(irq), 32'h0);
        tick(1);
        check("mask_irq0b", 32'(irq), 32'h0);
        sw_in = 4'b0011; tick(6);
        check("rise_stable", 32'(sw_stable), 32'h3);
        tick(1);
        check("rise_cap", 32'(edge_capture), 32'h2);
        check("irq_lag", 32'(irq), 32'h0);
        tick(1);
        check("irq_set", 32'(irq), 32'h1);
        bus_write(2'd3, 4'b0010);
        check("irq_clr_cap", 32'(edge_capture), 32'h0);
        check("irq_still", 32'(irq), 32'h1);
        tick(1);
        check("irq_clr", 32'(irq), 32'h0);

        // W1C on the exact cycle sw_stable[2] changes: set wins
        sw_in = 4'b0111; tick(6);
        check("sim_stable", 32'(sw_stable), 32'h7);
        bus_write(2'd3, 4'b0100);
        check("sim_set_wins", 32'(edge_capture), 32'h4);
        check("sim_irq", 32'(irq), 32'h0);

        // Reads: bits 0,2 fall and bit3 rises -> stable 1010, capture 1101
        sw_in = 4'b1010; tick(7);
        check("rd_stable", 32'(sw_stable), 32'ha);
        bus_read(2'd0);
        check("rd_data", 32'(readdata), 32'ha);
        bus_read(2'd1);
        check("rd_rsvd", 32'(readdata), 32'h0);
        bus_read(2'd3);
        check("rd_edge", 32'(readdata), 32'hd);
        tick(3);
        check("rd_hold", 32'(readdata), 32'hd);
        address = 2'd2; writedata = 4'b0100; read = 1'b1; write = 1'b1;
        tick(1);
        read = 1'b0; write = 1'b0;
        check("rd_prewrite", 32'(readdata), 32'h2);
        tick(1);
        check("new_mask_irq", 32'(irq), 32'h1);

        // Reset 2 cycles before a pending acceptance of bits 0 and 2
        sw_in = 4'b1111; tick(4);
        reset = 1'b1; tick(2);
        reset = 1'b0;
        check("mid_rst_stable", 32'(sw_stable), 32'h0);
        check("mid_rst_cap",    32'(edge_capture), 32'h0);
        check("mid_rst_irq",    32'(irq), 32'h0);
        check("mid_rst_rdata",  32'(readdata), 32'h0);
        bus_read(2'd2);
        check("mid_rst_mask", 32'(readdata), 32'h0);
        bus_write(2'd2, 4'b1111);
        tick(3);
        check("post_rst_early", 32'(sw_stable), 32'h0);
        tick(1);
        check("post_rst_stable", 32'(sw_stable), 32'hf);
        tick(1);
        check("post_rst_cap", 32'(edge_capture), 32'hf);
        check("post_rst_irq_lag", 32'(irq), 32'h0);
        tick(1);
        check("post_rst_irq", 32'(irq), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
